hog_pix_feeder: RTL

Pixel-neighbour feeder for the `hog` feature extractor; it is the producer side of the hog `ready`/`request`/`i_data` interface. On `start` it walks a grayscale frame stored in an external synchronous-read memory in HOG cell order. For each pixel it fetches the four neighbours (top, bottom, left, right), packs them into one word and presents the word to hog, holding it until hog consumes it. Out-of-frame neighbours are replaced by zero.

---
 rtl/hog_pix_feeder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hog_pix_feeder.sv
// hog_pix_feeder: walks a frame in HOG cell order and presents {top,bot,left,right} neighbour words to hog.
module hog_pix_feeder #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int CELL   = 8,
  parameter int ADDR_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               request,
  output logic               ready,
  output logic [4*PIX_W-1:0] i_data,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic               busy,
  output logic               done
);
  localparam int LC = $clog2(CELL);
  localparam int CW = 16;
  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, CAP, HOLD} state_t;
  state_t state, nxt;
  logic [CW-1:0] px, py, cx, cy, x, y;
  logic [ADDR_W-1:0] row_base, ctr;
  logic [PIX_W-1:0] top_r, bot_r, left_r;
  logic oob_t, oob_b, oob_l, oob_r, px_w, py_w, cx_w, cy_w, consume, last;
  assign x        = (cx << LC) | px;
  assign y        = (cy << LC) | py;
  assign ctr      = row_base + ADDR_W'(x);
  assign oob_t    = y == '0;
  assign oob_b    = y == CW'(IMG_H - 1);
  assign oob_l    = x == '0;
  assign oob_r    = x == CW'(IMG_W - 1);
  assign px_w     = px == CW'(CELL - 1);
  assign py_w     = py == CW'(CELL - 1);
  assign cx_w     = cx == CW'(IMG_W / CELL - 1);
  assign cy_w     = cy == CW'(IMG_H / CELL - 1);
  assign last     = px_w && py_w && cx_w && cy_w;
  assign consume  = state == HOLD && ready && request;
  assign busy     = state != IDLE;
  // Reads are issued combinationally so data lands in the following fetch state.
  always_comb begin
    nxt      = state;
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state)
      IDLE: nxt = start ? F0 : IDLE;
      F0: begin
        mem_rd   = !oob_t;
        mem_addr = oob_t ? '0 : ctr - ADDR_W'(IMG_W);
        nxt      = F1;
      end
      F1: begin
        mem_rd   = !oob_b;
        mem_addr = oob_b ? '0 : ctr + ADDR_W'(IMG_W);
        nxt      = F2;
      end
      F2: begin
        mem_rd   = !oob_l;
        mem_addr = oob_l ? '0 : ctr - 1'b1;
        nxt      = F3;
      end
      F3: begin
        mem_rd   = !oob_r;
        mem_addr = oob_r ? '0 : ctr + 1'b1;
        nxt      = CAP;
      end
      CAP:     nxt = HOLD;
      HOLD:    nxt = consume ? (last ? IDLE : F0) : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      px       <= '0;
      py       <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      top_r    <= '0;
      bot_r    <= '0;
      left_r   <= '0;
      i_data   <= '0;
      ready    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      done  <= consume && last;
      if (state == IDLE && start) begin
        px       <= '0;
        py       <= '0;
        cx       <= '0;
        cy       <= '0;
        row_base <= '0;
      end
      if (state == F1) top_r <= oob_t ? '0 : mem_rdata;
      if (state == F2) bot_r <= oob_b ? '0 : mem_rdata;
      if (state == F3) left_r <= oob_l ? '0 : mem_rdata;
      if (state == CAP) begin
        i_data <= {top_r, bot_r, left_r, oob_r ? '0 : mem_rdata};
        ready  <= 1'b1;
      end
      if (consume) begin
        ready <= 1'b0;
        px    <= px_w ? '0 : px + 1'b1;
        if (px_w) py <= py_w ? '0 : py + 1'b1;
        if (px_w && py_w) cx <= cx_w ? '0 : cx + 1'b1;
        if (px_w && py_w && cx_w) cy <= cy_w ? '0 : cy + 1'b1;
        // Leaving a cell jumps back up CELL-1 rows; otherwise step one row down.
        if (px_w)
          row_base <= last ? '0 :
                      (py_w && !cx_w) ? row_base - ADDR_W'((CELL - 1) * IMG_W) :
                      row_base + ADDR_W'(IMG_W);
      end
    end
  end
endmodule
